mux_scan_ctrl: RTL

MUX_SCAN_CTRL -- requirements
Module: mux_scan_ctrl

---
 rtl/mux_scan_pkg.sv | 22 ++
 rtl/mux_scan_ctrl.sv | 89 ++++++++
 2 files changed

// File: rtl/mux_scan_pkg.sv
// mux_scan_pkg: shared types, sizes and channel-walk helpers for the mux scan controller
package mux_scan_pkg;
  localparam int NCH = 4;
  localparam int SEL_W = 2;
  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;
  typedef struct packed {
    logic none;
    logic [SEL_W-1:0] ch;
  } nxt_t;
  // next enabled channel strictly above cur; none=1 when the frame is exhausted
  function automatic nxt_t next_ch(input logic [NCH-1:0] m, input logic [SEL_W-1:0] cur);
    next_ch = '{none: 1'b1, ch: '0};
    for (int i = NCH - 1; i >= 0; i--)
      if (i > int'(cur) && m[i]) next_ch = '{none: 1'b0, ch: SEL_W'(i)};
  endfunction
  // lowest enabled channel of a mask
  function automatic logic [SEL_W-1:0] first_ch(input logic [NCH-1:0] m);
    first_ch = '0;
    for (int i = NCH - 1; i >= 0; i--)
      if (m[i]) first_ch = SEL_W'(i);
  endfunction
endpackage

// File: rtl/mux_scan_ctrl.sv
// mux_scan_ctrl: walks a 4:1 mux select over enabled channels, samples y per channel, publishes a frame
module mux_scan_ctrl
  import mux_scan_pkg::*;
#(
  parameter int DWELL = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             cont,
  input  logic [NCH-1:0]   mask,
  input  logic             y,
  input  logic             ready,
  output logic [SEL_W-1:0] sel,
  output logic [NCH-1:0]   data,
  output logic             valid,
  output logic             busy
);
  localparam logic [3:0] RELOAD = 4'(DWELL - 1);
  state_t           state_q, state_d;
  logic [NCH-1:0]   mask_q, mask_d, shadow_q, shadow_d, data_q, data_d;
  logic [SEL_W-1:0] sel_q, sel_d;
  logic [3:0]       cnt_q, cnt_d;
  logic             valid_q, valid_d, busy_q, busy_d;
  nxt_t             nx;
  // next-state: start a frame, dwell and capture per channel, publish when the output slot frees up
  always_comb begin
    state_d = state_q;
    mask_d = mask_q;
    sel_d = sel_q;
    cnt_d = cnt_q;
    shadow_d = shadow_q;
    data_d = data_q;
    valid_d = valid_q & ~ready;
    nx = next_ch(mask_q, sel_q);
    case (state_q)
      IDLE: if (start && mask != '0) begin
        mask_d = mask;
        sel_d = first_ch(mask);
        cnt_d = RELOAD;
        shadow_d = '0;
        state_d = SCAN;
      end
      SCAN: if (cnt_q != '0) cnt_d = cnt_q - 4'd1;
      else begin
        shadow_d[sel_q] = y;
        state_d = nx.none ? DONE : SCAN;
        sel_d = nx.none ? sel_q : nx.ch;
        cnt_d = RELOAD;
      end
      DONE: if (!valid_q || ready) begin
        data_d = shadow_q;
        valid_d = 1'b1;
        state_d = cont ? SCAN : IDLE;
        sel_d = cont ? first_ch(mask_q) : '0;
        cnt_d = cont ? RELOAD : '0;
        shadow_d = cont ? '0 : shadow_q;
      end
      default: state_d = IDLE;
    endcase
    busy_d = state_d != IDLE;
  end
  // state and registered outputs; reset drops any partial frame
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      mask_q <= '0;
      sel_q <= '0;
      cnt_q <= '0;
      shadow_q <= '0;
      data_q <= '0;
      valid_q <= 1'b0;
      busy_q <= 1'b0;
    end else begin
      state_q <= state_d;
      mask_q <= mask_d;
      sel_q <= sel_d;
      cnt_q <= cnt_d;
      shadow_q <= shadow_d;
      data_q <= data_d;
      valid_q <= valid_d;
      busy_q <= busy_d;
    end
  end
  assign sel = sel_q;
  assign data = data_q;
  assign valid = valid_q;
  assign busy = busy_q;
endmodule
